// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: CPU byte-bus port of the multiply/divide coprocessor.
// master drives strobes, address and write data; slave returns data and status.
interface muldiv_seq_if #(
    parameter int AW = 3
);
    logic          CS;
    logic          WR;
    logic          RD;
    logic [AW-1:0] ADDR;
    logic [7:0]    DIN;
    logic [7:0]    DOUT;
    logic          BUSY;
    logic          IRQ;

    modport master (
        output CS, WR, RD, ADDR, DIN,
        input  DOUT, BUSY, IRQ
    );

    modport slave (
        input  CS, WR, RD, ADDR, DIN,
        output DOUT, BUSY, IRQ
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: shift-add multiplier / restoring divider on the CPU byte bus.
// Define MULDIV_SIGNED_EN for two's-complement operands and the FIX state.
module muldiv_seq #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input logic         CLK,
    input logic         RES,
    muldiv_seq_if.slave bus
);
    localparam int N  = W / 8;
    localparam int CW = $clog2(W + 1);
    localparam logic [AW-1:0] CTRL_ADDR = AW'(2 * N);

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, bs_q, am, bm;
    logic [2*W-1:0] r_q, acc_q, step;
    logic [W:0]     sum, trial;
    logic [CW-1:0]  cnt_q;
    logic           mode_q, sgn_q, ie_q, done_q, dz_q, zero_q;
    logic           wr_en, ctrl_wr, start, stat_rd, busy;
    logic           sa, sb, sgn_in, div_zero;
    logic [7:0]     rdata;

    assign wr_en    = bus.CS && bus.WR;
    assign ctrl_wr  = wr_en && bus.ADDR == CTRL_ADDR;
    assign start    = ctrl_wr && bus.DIN[0];
    assign stat_rd  = bus.CS && bus.RD && bus.ADDR == CTRL_ADDR;
    assign div_zero = bus.DIN[3] && b_q == '0;

`ifdef MULDIV_SIGNED_EN
    logic           neg_q, negr_q;
    logic [2*W-1:0] fix;

    assign sgn_in = bus.DIN[4];
    assign sa     = sgn_in && a_q[W-1];
    assign sb     = sgn_in && b_q[W-1];

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
        end else if (start) begin
            neg_q  <= sa ^ sb;
            negr_q <= sa;
        end
    end

    // Quotient/product sign from both operands; remainder follows the dividend.
    always_comb begin
        fix = acc_q;
        if (!mode_q) begin
            if (neg_q) fix = -acc_q;
        end else begin
            if (neg_q)  fix[W-1:0]   = -acc_q[W-1:0];
            if (negr_q) fix[2*W-1:W] = -acc_q[2*W-1:W];
        end
    end
`else
    assign sgn_in = 1'b0;
    assign sa     = 1'b0;
    assign sb     = 1'b0;
`endif

    assign am = sa ? -a_q : a_q;
    assign bm = sb ? -b_q : b_q;

    // acc holds {hi, lo}: mul {partial sum, multiplier}, div {remainder, quotient}.
    always_comb begin
        sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, bs_q} : '0);
        trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, bs_q};
        if (!mode_q)
            step = {sum, acc_q[W-1:1]};
        else if (!trial[W])
            step = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        else
            step = {acc_q[2*W-2:0], 1'b0};
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = state_q != IDLE;
        if (start) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (zero_q)
                        state_d = FINISH;
                    else if (cnt_q == CW'(1))
`ifdef MULDIV_SIGNED_EN
                        state_d = sgn_q ? FIX : FINISH;
`else
                        state_d = FINISH;
`endif
                end
`ifdef MULDIV_SIGNED_EN
                FIX:     state_d = FINISH;
`endif
                FINISH:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            a_q    <= '0;
            b_q    <= '0;
            bs_q   <= '0;
            r_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            sgn_q  <= 1'b0;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wr_en && bus.ADDR == AW'(k))
                    a_q[8*k +: 8] <= bus.DIN;
                if (wr_en && bus.ADDR == AW'(N + k))
                    b_q[8*k +: 8] <= bus.DIN;
            end
            if (start) begin
                mode_q <= bus.DIN[3];
                sgn_q  <= sgn_in;
                ie_q   <= bus.DIN[5];
                done_q <= 1'b0;
                dz_q   <= 1'b0;
                zero_q <= div_zero;
                cnt_q  <= CW'(W);
                bs_q   <= bm;
                // Divide by zero preloads its final answer and skips the steps.
                acc_q  <= div_zero ? {a_q, {W{1'b1}}} : {{W{1'b0}}, am};
            end else begin
                if (ctrl_wr) ie_q <= bus.DIN[5];
                if (stat_rd) done_q <= 1'b0;
                unique case (state_q)
                    RUN: begin
                        if (!zero_q) begin
                            acc_q <= step;
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
`ifdef MULDIV_SIGNED_EN
                    FIX: acc_q <= fix;
`endif
                    FINISH: begin
                        r_q    <= acc_q;
                        done_q <= 1'b1;
                        dz_q   <= zero_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 2 * N; k++)
            if (bus.ADDR == AW'(k)) rdata = r_q[8*k +: 8];
        if (bus.ADDR == CTRL_ADDR)
            rdata = {2'b00, ie_q, sgn_q, mode_q, dz_q, done_q, busy};
    end

    assign bus.DOUT = rdata;
    assign bus.BUSY = busy;
    assign bus.IRQ  = done_q && ie_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed bus traffic against a latency-aware
// arithmetic model of muldiv_seq, compared on every cycle.
module tb_muldiv_seq;
    localparam int W  = 16;
    localparam int AW = 3;
    localparam int N  = W / 8;
    localparam logic [AW-1:0] CTRL = AW'(2 * N);

    logic CLK = 1'b0;
    logic RES;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_if #(.AW(AW)) bus ();
    muldiv_seq #(.W(W), .AW(AW)) dut (.CLK(CLK), .RES(RES), .bus(bus));

    always #5 CLK = ~CLK;

    logic [W-1:0]   m_a = '0, m_b = '0;
    logic [2*W-1:0] m_r = '0, m_pend = '0;
    logic m_active = 0, m_done = 0, m_dz = 0, m_pdz = 0;
    logic m_ie = 0, m_mode = 0, m_sgn = 0;
    int   cyc = 0, fin = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void calc(input logic [W-1:0] a, b,
                                 input logic mode, sgn,
                                 output logic [2*W-1:0] res,
                                 output logic dz, output int lat);
        logic signed [2*W-1:0] xa, xb, p;
        logic signed [W-1:0] qa, qb;
        dz  = 1'b0;
        lat = sgn ? W + 2 : W + 1;
        xa  = {{W{a[W-1]}}, a};
        xb  = {{W{b[W-1]}}, b};
        qa  = a;
        qb  = b;
        if (mode && b == '0) begin
            res = {a, {W{1'b1}}};
            dz  = 1'b1;
            lat = 2;
        end else if (!mode) begin
            p   = xa * xb;
            res = sgn ? p : {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else if (!sgn) begin
            res = {a % b, a / b};
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            res = {{W{1'b0}}, a};
        end else begin
            res = {W'(qa % qb), W'(qa / qb)};
        end
    endfunction

    function automatic logic [7:0] exp_dout(input logic [AW-1:0] ad);
        if (int'(ad) < 2 * N) return m_r[8*int'(ad) +: 8];
        if (ad == CTRL)
            return {2'b00, m_ie, m_sgn, m_mode, m_dz, m_done, m_active};
        return 8'h00;
    endfunction

    // Reference model: result computed at START, published at its finish edge.
    initial forever begin
        int lat;
        @(posedge CLK or negedge RES);
        if (!RES) begin
            m_a = '0; m_b = '0; m_r = '0;
            m_active = 0; m_done = 0; m_dz = 0;
            m_ie = 0; m_mode = 0; m_sgn = 0;
        end else if (CLK) begin
            cyc++;
            if (bus.CS && bus.WR)
                for (int k = 0; k < N; k++) begin
                    if (bus.ADDR == AW'(k)) m_a[8*k +: 8] = bus.DIN;
                    if (bus.ADDR == AW'(N + k)) m_b[8*k +: 8] = bus.DIN;
                end
            if (bus.CS && bus.WR && bus.ADDR == CTRL && bus.DIN[0]) begin
                m_mode = bus.DIN[3];
`ifdef MULDIV_SIGNED_EN
                m_sgn = bus.DIN[4];
`else
                m_sgn = 1'b0;
`endif
                m_ie = bus.DIN[5];
                calc(m_a, m_b, m_mode, m_sgn, m_pend, m_pdz, lat);
                fin = cyc + lat;
                m_active = 1; m_done = 0; m_dz = 0;
            end else begin
                if (bus.CS && bus.WR && bus.ADDR == CTRL) m_ie = bus.DIN[5];
                if (m_active && cyc == fin) begin
                    m_r = m_pend; m_done = 1; m_dz = m_pdz; m_active = 0;
                end else if (bus.CS && bus.RD && bus.ADDR == CTRL) begin
                    m_done = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("busy", bus.BUSY, m_active);
            check("irq", bus.IRQ, m_done & m_ie);
            check("dout", bus.DOUT, exp_dout(bus.ADDR));
        end
    end

    task automatic wr(input logic [AW-1:0] ad, input logic [7:0] d);
        bus.CS = 1'b1; bus.WR = 1'b1; bus.ADDR = ad; bus.DIN = d;
        @(posedge CLK); #1;
        bus.CS = 1'b0; bus.WR = 1'b0;
    endtask

    task automatic wr_ops(input logic [W-1:0] a, b);
        for (int k = 0; k < N; k++) wr(AW'(k), a[8*k +: 8]);
        for (int k = 0; k < N; k++) wr(AW'(N + k), b[8*k +: 8]);
    endtask

    task automatic read_r(output logic [2*W-1:0] r);
        for (int k = 0; k < 2 * N; k++) begin
            bus.ADDR = AW'(k);
            @(negedge CLK);
            r[8*k +: 8] = bus.DOUT;
            @(posedge CLK); #1;
        end
    endtask

    task automatic read_status(output logic [7:0] v);
        bus.CS = 1'b1; bus.RD = 1'b1; bus.ADDR = CTRL;
        @(negedge CLK);
        v = bus.DOUT;
        @(posedge CLK); #1;
        bus.CS = 1'b0; bus.RD = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.BUSY && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic [7:0] c,
                          input int lat, input logic [2*W-1:0] res,
                          input string nm);
        int n;
        logic [2*W-1:0] r;
        wr_ops(a, b);
        wr(CTRL, c);
        wait_idle(n);
        check({nm, "_lat"}, n, lat);
        read_r(r);
        check({nm, "_r"}, r, res);
    endtask

    initial begin
        logic [7:0] v, d;
        logic [2*W-1:0] r;
        int n, sel;
        RES = 1'b0;
        bus.CS = 0; bus.WR = 0; bus.RD = 0; bus.ADDR = '0; bus.DIN = '0;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b1;
        chk_en = 1'b1;
        read_status(v);
        check("rst_status", v, 8'h00);
        read_r(r);
        check("rst_r", r, 0);

        run_op(16'h1234, 16'h5678, 8'h01, 17, 32'h06260060, "mul");
        check("irq_off", bus.IRQ, 0);
        wr(CTRL, 8'h20);
        check("irq_on", bus.IRQ, 1);
        read_status(v);
        check("mul_status", v, 8'h22);
        check("irq_clr", bus.IRQ, 0);
        read_status(v);
        check("done_clr", v, 8'h20);

        run_op(16'hFFFF, 16'h0010, 8'h09, 17, 32'h000F0FFF, "div");
        read_status(v);
        check("div_status", v, 8'h0A);
        run_op(16'h1234, 16'h0000, 8'h09, 2, 32'h1234FFFF, "dz");
        read_status(v);
        check("dz_status", v, 8'h0E);

        wr_ops(16'h1234, 16'h5678);
        wr(CTRL, 8'h01);
        wr_ops(16'h0003, 16'h0004);
        wr(CTRL, 8'h01);
        read_r(r);
        check("hold_r", r, 32'h1234FFFF);
        wait_idle(n);
        read_r(r);
        check("abort_r", r, 32'h0000000C);
        read_status(v);
        check("abort_status", v, 8'h02);

        wr(CTRL, 8'h21);
        repeat (5) begin @(posedge CLK); #1; end
        RES = 1'b0;
        #1;
        check("rst_busy", bus.BUSY, 0);
        check("rst_irq", bus.IRQ, 0);
        @(posedge CLK); #1;
        RES = 1'b1;
        read_r(r);
        check("rst2_r", r, 0);
        read_status(v);
        check("rst2_status", v, 8'h00);
        run_op(16'h0003, 16'h0004, 8'h01, 17, 32'h0000000C, "after_rst");

`ifdef MULDIV_SIGNED_EN
        run_op(16'hFFFA, 16'h0007, 8'h11, 18, 32'hFFFFFFD6, "smul");
        read_status(v);
        check("smul_status", v, 8'h12);
        run_op(16'hFFF9, 16'h0002, 8'h19, 18, 32'hFFFFFFFD, "sdiv");
        run_op(16'h8000, 16'hFFFF, 8'h19, 18, 32'h00008000, "sovf");
`else
        run_op(16'hFFFA, 16'h0007, 8'h11, 17, 32'h0006FFD6, "nosgn");
        read_status(v);
        check("nosgn_status", v, 8'h02);
`endif

        repeat (1500) begin
            sel = $urandom_range(0, 99);
            d = 8'($urandom);
            if (sel < 3) begin
                d[0] = 1'b1;
                wr(CTRL, d);
            end else if (sel < 6) begin
                d[0] = 1'b0;
                wr(CTRL, d);
            end else if (sel < 20) begin
                if ($urandom_range(0, 7) == 0) d = 8'h00;
                wr(AW'($urandom_range(0, 2 * N - 1)), d);
            end else if (sel < 23) begin
                wr(AW'($urandom_range(2 * N + 1, 2 ** AW - 1)), d);
            end else if (sel < 28) begin
                read_status(v);
            end else if (sel == 28) begin
                RES = 1'b0;
                @(posedge CLK); #1;
                RES = 1'b1;
            end else begin
                bus.ADDR = AW'($urandom_range(0, 2 ** AW - 1));
                @(posedge CLK); #1;
            end
        end
        wait_idle(n);
        check("final_idle", bus.BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
